conway_sequencer: RTL and testbench

//  Generation controller for a game-of-life cell array. Drives the shared ena/load lines of all cells.

---
 rtl/conway_sequencer_if.sv | 51 +++++
 rtl/conway_sequencer.sv | 158 +++++++++++++++
 tb/tb_conway_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conway_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : conway_sequencer_if
// Purpose  : Bundles the command, configuration, grid-observation and cell
//            control signals exchanged between the user/command logic, the
//            generation sequencer and the cell grid.
// Signals  : cmd_load/cmd_run/cmd_pause/cmd_step  command pulses
//            tick_period [TICK_W]  idle RUN cycles between generations
//            max_gens    [GEN_W]   generation limit, 0 = unlimited
//            grid_q/grid_d [N]     current / next state of every cell
//            cell_ena, cell_load   shared cell control lines
//            running, done, stable, gen_count [GEN_W]  status
// Modports : master - command/grid side; slave - the sequencer
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface conway_sequencer_if #(
  parameter int N      = 64,
  parameter int TICK_W = 24,
  parameter int GEN_W  = 16
) ();
  logic              cmd_load;
  logic              cmd_run;
  logic              cmd_pause;
  logic              cmd_step;
  logic [TICK_W-1:0] tick_period;
  logic [GEN_W-1:0]  max_gens;
  logic [N-1:0]      grid_q;
  logic [N-1:0]      grid_d;
  logic              cell_ena;
  logic              cell_load;
  logic              running;
  logic              done;
  logic              stable;
  logic [GEN_W-1:0]  gen_count;

  modport master (
    output cmd_load, cmd_run, cmd_pause, cmd_step, tick_period, max_gens,
           grid_q, grid_d,
    input  cell_ena, cell_load, running, done, stable, gen_count
  );

  modport slave (
    input  cmd_load, cmd_run, cmd_pause, cmd_step, tick_period, max_gens,
           grid_q, grid_d,
    output cell_ena, cell_load, running, done, stable, gen_count
  );
endinterface

`default_nettype wire

// File: rtl/conway_sequencer.sv
//------------------------------------------------------------------------------
// Module   : conway_sequencer
// Purpose  : Generation controller for a game-of-life cell array. Drives the
//            shared ena/load lines of all cells, paces generations with a
//            programmable tick prescaler, supports load/run/pause/single-step,
//            counts generations and stops on a generation limit or when the
//            board is stable (next state equals current state).
// Ports    : clk  - clock, all logic on posedge
//            rst  - synchronous active-low reset
//            bus  - conway_sequencer_if.slave (commands, tick_period,
//                   max_gens, grid_q/grid_d in; cell_ena, cell_load, running,
//                   done, stable, gen_count out)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module conway_sequencer #(
  parameter int N      = 64,
  parameter int TICK_W = 24,
  parameter int GEN_W  = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  conway_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PAUSED = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  state_t            r_ret, w_ret_nxt;       // state to resume after a STEP
  logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [GEN_W-1:0]  r_gen_count, w_gen_count_nxt;
  logic [GEN_W-1:0]  w_gen_inc;
  logic              r_stable, w_stable_nxt;
  logic              r_cell_ena, r_cell_load, r_running, r_done;

  logic [N-1:0]      w_grid_q, w_grid_d;
  logic              w_board_stable;

  assign w_grid_q       = bus.grid_q;
  assign w_grid_d       = bus.grid_d;
  assign w_board_stable = (w_grid_d == w_grid_q);
  assign w_gen_inc      = r_gen_count + GEN_W'(1);

  // Next-state / datapath logic
  always_comb begin
    w_state_nxt     = r_state;
    w_ret_nxt       = r_ret;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_gen_count_nxt = r_gen_count;
    w_stable_nxt    = r_stable;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_load) w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_gen_count_nxt = '0;
        w_stable_nxt    = 1'b0;
        w_state_nxt     = S_PAUSED;
      end

      S_PAUSED: begin
        if (bus.cmd_load) begin
          w_state_nxt = S_LOAD;
        end else if (bus.cmd_step) begin
          w_state_nxt = S_STEP;
          w_ret_nxt   = S_PAUSED;
        end else if (bus.cmd_run) begin
          w_state_nxt    = S_RUN;
          w_tick_cnt_nxt = '0;
        end
      end

      S_RUN: begin
        if (bus.cmd_load) begin
          w_state_nxt = S_LOAD;
        end else if (bus.cmd_pause) begin
          w_state_nxt = S_PAUSED;
        end else if (r_tick_cnt >= bus.tick_period) begin
          // >= rather than == so a tick_period reduced below the current
          // count fires on the next cycle instead of waiting for a wrap.
          w_tick_cnt_nxt = '0;
          w_state_nxt    = S_STEP;
          w_ret_nxt      = S_RUN;
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
        end
      end

      S_STEP: begin
        w_gen_count_nxt = w_gen_inc;
        if (w_board_stable) begin
          w_stable_nxt = 1'b1;
          w_state_nxt  = S_DONE;
        end else if ((bus.max_gens != '0) && (w_gen_inc == bus.max_gens)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = r_ret;
        end
      end

      S_DONE: begin
        if (bus.cmd_load) w_state_nxt = S_LOAD;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register. Outputs are decoded from the next state and registered,
  // so they track the state register exactly with no combinational path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ret       <= S_IDLE;
      r_tick_cnt  <= '0;
      r_gen_count <= '0;
      r_stable    <= 1'b0;
      r_cell_ena  <= 1'b0;
      r_cell_load <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret       <= w_ret_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_gen_count <= w_gen_count_nxt;
      r_stable    <= w_stable_nxt;
      r_cell_ena  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_STEP);
      r_cell_load <= (w_state_nxt == S_LOAD);
      r_running   <= (w_state_nxt == S_RUN) ||
                     ((w_state_nxt == S_STEP) && (w_ret_nxt == S_RUN));
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.cell_ena  = r_cell_ena;
  assign bus.cell_load = r_cell_load;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.stable    = r_stable;
  assign bus.gen_count = r_gen_count;

endmodule

`default_nettype wire

// File: tb/tb_conway_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_conway_sequencer
// Purpose  : Self-checking bench for conway_sequencer. An 8x8 life board with
//            dead borders is attached as the cell array; expected cell_ena
//            pulses are queued by the stimulus and checked by a monitor.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_conway_sequencer;
  localparam int N      = 64;
  localparam int TICK_W = 24;
  localparam int GEN_W  = 16;
  localparam int SIDE   = 8;
  localparam int RUN_CAP = 8;   // free-run generations before forcing a pause

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conway_sequencer_if #(.N(N), .TICK_W(TICK_W), .GEN_W(GEN_W)) sif ();

  conway_sequencer #(.N(N), .TICK_W(TICK_W), .GEN_W(GEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // ---------------- life rules and cell array ----------------
  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] r;
    int n;
    r = '0;
    for (int y = 0; y < SIDE; y++) begin
      for (int x = 0; x < SIDE; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < SIDE &&
                x + dx >= 0 && x + dx < SIDE)
              n += int'(b[(y + dy) * SIDE + x + dx]);
        r[y * SIDE + x] = (n == 3) || (n == 2 && b[y * SIDE + x]);
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] pattern(input int sel);
    logic [N-1:0] p;
    p = '0;
    case (sel)
      1: begin p[3*SIDE+2] = 1; p[3*SIDE+3] = 1; p[3*SIDE+4] = 1; end       // blinker
      2: begin p[2*SIDE+2] = 1; p[2*SIDE+3] = 1; p[3*SIDE+2] = 1; p[3*SIDE+3] = 1; end // block
      3: begin p[0*SIDE+1] = 1; p[1*SIDE+2] = 1; p[2*SIDE+0] = 1;
               p[2*SIDE+1] = 1; p[2*SIDE+2] = 1; end                        // glider
      4: p = {$urandom, $urandom};
      default: p = '0;                                                     // empty
    endcase
    return p;
  endfunction

  logic [N-1:0] state0 = '0;
  logic [N-1:0] cells  = '0;
  assign sif.grid_q = cells;
  assign sif.grid_d = life(cells);
  always @(posedge clk) if (sif.cell_ena) cells <= sif.cell_load ? state0 : sif.grid_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int t;
    bit load;
    int gen;
    bit run;
  } pulse_t;
  pulse_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    pulse_t p;
    if (sif.cell_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse @cycle %0d: got cell_ena=1 expected 0", cyc);
      end else begin
        p = exp_q.pop_front();
        check("pulse_cycle",   64'(cyc),           64'(p.t));
        check("pulse_load",    64'(sif.cell_load), 64'(p.load));
        check("pulse_gen",     64'(sif.gen_count), 64'(p.gen));
        check("pulse_running", 64'(sif.running),   64'(p.run));
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [N-1:0] boards [0:15];
  int m_gen    = 0;
  bit m_done   = 0;
  bit m_stable = 0;
  int m_max    = 0;

  // Effect of one generation step, taken from the life sequence.
  task automatic model_step();
    int k;
    k = m_gen + 1;
    m_gen = k;
    if (boards[k] == boards[k-1]) begin
      m_stable = 1;
      m_done   = 1;
    end else if (m_max != 0 && k == m_max) begin
      m_done = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic issue(input bit ld, input bit pa, input bit st, input bit ru);
    sif.cmd_load = ld; sif.cmd_pause = pa; sif.cmd_step = st; sif.cmd_run = ru;
    tick();
    sif.cmd_load = 0; sif.cmd_pause = 0; sif.cmd_step = 0; sif.cmd_run = 0;
  endtask

  task automatic final_checks(input string tag);
    repeat (3) tick();
    check({tag, "_gen_count"}, 64'(sif.gen_count), 64'(m_gen));
    check({tag, "_done"},      64'(sif.done),      64'(m_done));
    check({tag, "_stable"},    64'(sif.stable),    64'(m_stable));
    check({tag, "_running"},   64'(sif.running),   64'd0);
    check({tag, "_board"},     cells == boards[m_gen] ? 64'd1 : 64'd0, 64'd1);
    check({tag, "_pending"},   64'(exp_q.size()),  64'd0);
    exp_q.delete();
  endtask

  task automatic do_load(input logic [N-1:0] pat);
    state0    = pat;
    boards[0] = pat;
    for (int k = 1; k < 16; k++) boards[k] = life(boards[k-1]);
    exp_q.push_back('{cyc + 1, 1'b1, m_gen, 1'b0});
    issue(1, 0, 1'($urandom_range(0, 1)), 0);  // load outranks a concurrent step
    m_gen = 0; m_done = 0; m_stable = 0;
    tick();
    check("load_gen_count", 64'(sif.gen_count), 64'd0);
    check("load_done",      64'(sif.done),      64'd0);
    check("load_stable",    64'(sif.stable),    64'd0);
    check("load_running",   64'(sif.running),   64'd0);
    check("load_cells",     cells == pat ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic scen_step(input int maxg, input int nsteps);
    m_max = maxg;
    sif.max_gens = GEN_W'(maxg);
    for (int i = 0; i < nsteps; i++) begin
      if (!m_done) begin
        exp_q.push_back('{cyc + 1, 1'b0, m_gen, 1'b0});
        model_step();
      end
      issue(0, 0, 1, 1'($urandom_range(0, 1)));   // step outranks run
      tick();
      tick();
    end
    final_checks("step");
  endtask

  task automatic scen_run(input int period, input int maxg);
    int c;
    m_max = maxg;
    sif.max_gens    = GEN_W'(maxg);
    sif.tick_period = TICK_W'(period);
    c = cyc;
    for (int k = 1; k <= RUN_CAP; k++) begin
      exp_q.push_back('{c + k * (period + 2), 1'b0, m_gen, 1'b1});
      model_step();
      if (m_done) break;
    end
    issue(0, 0, 0, 1);
    if (m_done) begin
      wait_until(c + m_gen * (period + 2) + 3);
      issue(0, 0, 1, 1);   // ignored once finished
      tick();
    end else begin
      // Now in the last expected STEP: the pause is ignored there and takes
      // effect on the following RUN cycle, ahead of any tick or run.
      wait_until(c + RUN_CAP * (period + 2));
      sif.cmd_pause = 1;
      sif.cmd_run   = 1'($urandom_range(0, 1));
      tick();
      tick();
      sif.cmd_pause = 0;
      sif.cmd_run   = 0;
      repeat (2 * period + 6) tick();
    end
    final_checks("run");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cell_ena"},  64'(sif.cell_ena),  64'd0);
    check({tag, "_cell_load"}, 64'(sif.cell_load), 64'd0);
    check({tag, "_running"},   64'(sif.running),   64'd0);
    check({tag, "_done"},      64'(sif.done),      64'd0);
    check({tag, "_stable"},    64'(sif.stable),    64'd0);
    check({tag, "_gen_count"}, 64'(sif.gen_count), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    sif.cmd_load = 0; sif.cmd_run = 0; sif.cmd_pause = 0; sif.cmd_step = 0;
    sif.tick_period = '0;
    sif.max_gens    = '0;

    rst = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1;
    issue(0, 0, 1, 1);            // IDLE ignores everything but load
    repeat (4) tick();

    do_load(pattern(1)); scen_run(3, 0);            // blinker cadence, paused
    do_load(pattern(2)); scen_step(0, 3);           // block: first step stable
    do_load(pattern(1)); scen_run(0, 4);            // blinker, limit 4
    do_load(pattern(0)); scen_run(2, 0);            // empty board is stable

    for (int i = 0; i < 12; i++) begin
      do_load(pattern($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1)
        scen_run($urandom_range(0, 4), $urandom_range(0, 6));
      else
        scen_step($urandom_range(0, 3), $urandom_range(1, 5));
    end

    // Reset in the middle of a free run.
    do_load(pattern(1));
    sif.tick_period = TICK_W'(3);
    sif.max_gens    = '0;
    c = cyc;
    exp_q.push_back('{c + 5,  1'b0, 0, 1'b1});
    exp_q.push_back('{c + 10, 1'b0, 1, 1'b1});
    issue(0, 0, 0, 1);
    wait_until(c + 12);
    rst = 0;
    tick();
    check_all_zero("midrun_reset");
    rst = 1;
    issue(0, 0, 0, 1);            // back in IDLE: run ignored
    repeat (20) tick();
    check_all_zero("after_reset");
    check("after_reset_pending", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
